// File: rtl/adc_lector_pkg.sv
// adc_lector_pkg: constants and types shared by the ADC capture block and its sample FIFO.
// Holds the capture/emitter state encodings, the sample width and the byte-order constant.
// Purely declarative: no logic, no latency, no flow control.
package adc_lector_pkg;

  // Bits shifted in per conversion; this revision of the ADC interface is fixed at 16.
  localparam int NBITS = 16;

  // Byte order towards the host: 1 = most significant byte first.
  localparam logic MSB_FIRST = 1'b1;

  typedef logic [NBITS-1:0] sample_t;

  // Capture FSM encodings.
  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_CONV  = 2'd1;
  localparam logic [1:0] C_SHIFT = 2'd2;
  localparam logic [1:0] C_STORE = 2'd3;

  // Emitter FSM encodings.
  localparam logic [2:0] E_IDLE = 3'd0;
  localparam logic [2:0] E_HI   = 3'd1;
  localparam logic [2:0] E_GAP1 = 3'd2;
  localparam logic [2:0] E_LO   = 3'd3;
  localparam logic [2:0] E_GAP2 = 3'd4;

  // Byte sent in the first strobe of a pair.
  function automatic logic [7:0] first_byte(input sample_t s);
    return MSB_FIRST ? s[15:8] : s[7:0];
  endfunction

  // Byte sent in the second strobe of a pair.
  function automatic logic [7:0] second_byte(input sample_t s);
    return MSB_FIRST ? s[7:0] : s[15:8];
  endfunction

endpackage

// File: rtl/adc_lector_fifo_muestras.sv
// fifo_muestras: synchronous sample FIFO, NBITS wide x DEPTH entries, head readable combinationally.
// Latency: a push is visible at the head the cycle after the write edge; pop advances at the edge.
// Backpressure: push is refused when full unless a pop happens in the same cycle; pop on empty is ignored.
//
// Ports: clk, rst_n (sync, active low), push/push_dat (write side), pop/head (read side),
//        full, empty (both derived from registered pointers).
// DEPTH must be a power of two and at least 2.
module fifo_muestras
  import adc_lector_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  sample_t push_dat,
  input  logic    pop,
  output sample_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full (MSBs differ) from empty (all bits equal).
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  sample_t     mem [DEPTH];

  logic wr_ok;
  logic rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // A pop in the same cycle frees the head slot, so a push on a full FIFO is still accepted;
  // the head is read before the edge that overwrites it.
  assign wr_ok = push && (!full || pop);
  assign rd_ok = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/adc_lector.sv
// adc_lector: on each flag_adc pulse reads one 16-bit sample from a serial ADC into a FIFO,
// then streams buffered samples to the host as strobed bytes (first byte per MSB_FIRST).
// Latency: flag_adc to FIFO write 2 + 34*SCLK_DIV cycles; FIFO non-empty to first Stb 1 cycle.
// Backpressure: rd_en gates starting a sample pair only; a full FIFO drops the sample and sets overflow.
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   flag_adc              one-cycle conversion request
//   adc_cs_n, adc_sclk    ADC chip select (active low) and serial clock (idle low)
//   adc_sdo               ADC serial data, MSB first
//   rd_en                 host ready (level)
//   dato, Stb             byte to host and its one-cycle strobe
//   busy, fifo_full       capture FSM active / FIFO holds FIFO_DEPTH samples
//   overflow              sticky: sample dropped or request missed; cleared only by reset
//
// Build option: define ADC_TEST_PATTERN_EN to store an incrementing 16-bit counter instead of
// the shifted ADC data (the SPI pins keep toggling exactly as in normal operation).
module adc_lector
  import adc_lector_pkg::*;
#(
  parameter int SCLK_DIV   = 2,
  parameter int NBITS      = adc_lector_pkg::NBITS,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag_adc,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  input  logic       adc_sdo,
  input  logic       rd_en,
  output logic [7:0] dato,
  output logic       Stb,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  // div_cnt covers both the setup window (0..2*SCLK_DIV) and one sclk half period.
  localparam int CW = $clog2(2 * SCLK_DIV + 1);
  localparam int HW = $clog2(2 * NBITS);

  localparam logic [CW-1:0] SETUP_LAST     = CW'(2 * SCLK_DIV);
  localparam logic [CW-1:0] HALF_LAST      = CW'(SCLK_DIV - 1);
  localparam logic [HW-1:0] HALF_CNT_LAST  = HW'(2 * NBITS - 1);

  // ---------------------------------------------------------------------------
  // Capture side
  // ---------------------------------------------------------------------------
  logic [1:0]       c_state;
  logic [CW-1:0]    div_cnt;
  logic [HW-1:0]    half_cnt;
  logic [NBITS-1:0] shreg;

  logic    store_ev;
  logic    missed;
  logic    drop;
  logic    push;
  logic    pop;
  logic    f_full;
  logic    f_empty;
  sample_t head;
  sample_t store_dat;

  assign store_ev = (c_state == C_STORE);
  assign missed   = flag_adc && (c_state != C_IDLE);
  assign push     = store_ev && (!f_full || pop);
  // A pop in the same cycle makes room, so only a push against a full, non-draining FIFO drops.
  assign drop     = store_ev && f_full && !pop;

  assign busy      = (c_state != C_IDLE);
  assign fifo_full = f_full;

  // Timeline for a request sampled at edge N (D = SCLK_DIV):
  //   N           IDLE -> CONV
  //   N+1         adc_cs_n falls (registered from the CONV state)
  //   N+1+2D      CONV -> SHIFT, first sclk rise, MSB sampled
  //   N+1+34D     32 half periods done (16 rises, last fall, trailing low half) -> STORE
  //   N+2+34D     FIFO write, adc_cs_n rises
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_state  <= C_IDLE;
      div_cnt  <= '0;
      half_cnt <= '0;
      shreg    <= '0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b0;
      overflow <= 1'b0;
    end else begin
      adc_cs_n <= !((c_state == C_CONV) || (c_state == C_SHIFT));
      if (missed || drop) overflow <= 1'b1;

      case (c_state)
        C_IDLE: begin
          if (flag_adc) begin
            c_state <= C_CONV;
            div_cnt <= '0;
          end
        end

        C_CONV: begin
          if (div_cnt == SETUP_LAST) begin
            c_state  <= C_SHIFT;
            div_cnt  <= '0;
            half_cnt <= '0;
            adc_sclk <= 1'b1;
            shreg    <= {shreg[NBITS-2:0], adc_sdo};
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        C_SHIFT: begin
          if (div_cnt == HALF_LAST) begin
            div_cnt <= '0;
            if (half_cnt == HALF_CNT_LAST) begin
              c_state <= C_STORE;
            end else begin
              half_cnt <= half_cnt + 1'b1;
              adc_sclk <= !adc_sclk;
              // Data is taken on the edge that drives sclk high.
              if (!adc_sclk) shreg <= {shreg[NBITS-2:0], adc_sdo};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        C_STORE: begin
          c_state <= C_IDLE;
        end

        default: begin
          c_state <= C_IDLE;
        end
      endcase
    end
  end

`ifdef ADC_TEST_PATTERN_EN
  // Pattern advances on every store attempt, dropped ones included, so gaps reveal overflows.
  sample_t tp_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tp_cnt <= '0;
    end else if (store_ev) begin
      tp_cnt <= tp_cnt + 1'b1;
    end
  end

  assign store_dat = tp_cnt;
`else
  assign store_dat = shreg;
`endif

  fifo_muestras #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (store_dat),
    .pop      (pop),
    .head     (head),
    .full     (f_full),
    .empty    (f_empty)
  );

  // ---------------------------------------------------------------------------
  // Emitter side
  // ---------------------------------------------------------------------------
  logic [2:0] e_state;
  logic [7:0] second_q;

  // rd_en is only consulted here, so a pair that has started always completes.
  assign pop = (e_state == E_IDLE) && !f_empty && rd_en;

  // dato/Stb are registered on entry to each state, so they are valid exactly while in it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_state  <= E_IDLE;
      dato     <= 8'h00;
      Stb      <= 1'b0;
      second_q <= 8'h00;
    end else begin
      case (e_state)
        E_IDLE: begin
          Stb <= 1'b0;
          if (pop) begin
            e_state  <= E_HI;
            dato     <= first_byte(head);
            second_q <= second_byte(head);
            Stb      <= 1'b1;
          end
        end

        E_HI: begin
          e_state <= E_GAP1;
          Stb     <= 1'b0;
        end

        E_GAP1: begin
          e_state <= E_LO;
          dato    <= second_q;
          Stb     <= 1'b1;
        end

        E_LO: begin
          e_state <= E_GAP2;
          Stb     <= 1'b0;
        end

        E_GAP2: begin
          e_state <= E_IDLE;
          Stb     <= 1'b0;
        end

        default: begin
          e_state <= E_IDLE;
          Stb     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_lector.sv
// tb_adc_lector: directed bench for adc_lector with a serial ADC model and a byte scoreboard.
// Expected bytes are queued when a capture is requested and compared with the strobed bytes.
// Define ADC_TEST_PATTERN_EN for both bench and RTL to expect counter samples instead.
module tb_adc_lector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flag_adc;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic       adc_sdo = 1'b0;
  logic       rd_en;
  logic [7:0] dato;
  logic       Stb;
  logic       busy;
  logic       fifo_full;
  logic       overflow;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [15:0] adc_word = 16'h0000;
  logic [15:0] cur_word = 16'h0000;
  int          bit_idx  = 15;
  logic        prev_cs  = 1'b1;
  logic        prev_sck = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc[$];

`ifdef ADC_TEST_PATTERN_EN
  logic [15:0] tp = 16'h0000;
`endif

  adc_lector #(
    .SCLK_DIV   (2),
    .NBITS      (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flag_adc  (flag_adc),
    .adc_cs_n  (adc_cs_n),
    .adc_sclk  (adc_sclk),
    .adc_sdo   (adc_sdo),
    .rd_en     (rd_en),
    .dato      (dato),
    .Stb       (Stb),
    .busy      (busy),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: loads the word when chip select falls, advances one bit on each sclk fall.
  always @(negedge clk) begin
    if (prev_cs && !adc_cs_n) begin
      cur_word = adc_word;
      bit_idx  = 15;
      adc_sdo  = adc_word[15];
    end else if (prev_sck && !adc_sclk) begin
      if (bit_idx > 0) bit_idx = bit_idx - 1;
      adc_sdo = cur_word[bit_idx];
    end
    prev_cs  = adc_cs_n;
    prev_sck = adc_sclk;
  end

  // Byte monitor.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && Stb === 1'b1) begin
      obs_q.push_back(dato);
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
`ifdef ADC_TEST_PATTERN_EN
    tp = 16'h0000;
`endif
  endtask

  // Pulse flag_adc for one edge and queue the bytes this capture should produce.
  task automatic start_capture(input logic [15:0] w, input bit keep);
    logic [15:0] e;
`ifdef ADC_TEST_PATTERN_EN
    e  = tp;
    tp = tp + 16'h0001;
`else
    e = w;
`endif
    adc_word = w;
    flag_adc = 1'b1;
    tick();
    flag_adc = 1'b0;
    if (keep) begin
      exp_q.push_back(e[15:8]);
      exp_q.push_back(e[7:0]);
    end
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy === 1'b1 && t < 300) begin
      tick();
      t++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic capture(input logic [15:0] w, input bit keep);
    start_capture(w, keep);
    wait_idle("capture");
    tick();
  endtask

  task automatic drain_check(input string tag);
    int n;
    int m;
    n = obs_q.size();
    m = exp_q.size();
    check({tag, "_nbytes"}, 32'(n), 32'(m));
    for (int i = 0; i < n && i < m; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    for (int i = 0; i + 1 < n; i += 2)
      check($sformatf("%s_pair%0d_gap", tag, i / 2), 32'(obs_cyc[i+1] - obs_cyc[i]), 32'd2);
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    int lowcnt;
    int scnt;

    rst_n    = 1'b0;
    flag_adc = 1'b0;
    rd_en    = 1'b0;

    // Reset values.
    tick();
    tick();
    check("rst_cs_n",      32'(adc_cs_n),  32'd1);
    check("rst_sclk",      32'(adc_sclk),  32'd0);
    check("rst_dato",      32'(dato),      32'h00);
    check("rst_stb",       32'(Stb),       32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_fifo_full", 32'(fifo_full), 32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    do_reset();

    // Single capture with timing.
    rd_en = 1'b1;
    start_capture(16'hA5C3, 1'b1);
    check("single_busy", 32'(busy), 32'd1);
    tick();
    lowcnt = 0;
    while (adc_cs_n === 1'b0 && lowcnt < 200) begin
      tick();
      lowcnt++;
    end
    check("single_cs_low_cycles", 32'(lowcnt), 32'd69);
    scnt = 0;
    while (Stb !== 1'b1 && scnt < 50) begin
      tick();
      scnt++;
    end
    check("single_stb_after_write", 32'(scnt), 32'd1);
    repeat (10) tick();
    drain_check("single");

    // Missed request: second pulse 20 cycles after the first.
    start_capture(16'h1234, 1'b1);
    repeat (19) tick();
    check("missed_busy", 32'(busy), 32'd1);
    check("missed_ovf_before", 32'(overflow), 32'd0);
    flag_adc = 1'b1;
    tick();
    flag_adc = 1'b0;
    check("missed_ovf_after", 32'(overflow), 32'd1);
    wait_idle("missed");
    repeat (20) tick();
    drain_check("missed");
    check("missed_ovf_sticky", 32'(overflow), 32'd1);

    // Back-pressure: fill the FIFO with rd_en low.
    do_reset();
    rd_en = 1'b0;
    for (int k = 1; k <= 8; k++) capture(16'(k), 1'b1);
    check("bp_fifo_full", 32'(fifo_full), 32'd1);
    check("bp_no_stb", 32'(obs_q.size()), 32'd0);
    check("bp_ovf_clear", 32'(overflow), 32'd0);

    // Ninth capture on a full FIFO is dropped.
    capture(16'hFFFF, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_still_full", 32'(fifo_full), 32'd1);
    rd_en = 1'b1;
    repeat (60) tick();
    drain_check("bp");
    check("bp_drained_full", 32'(fifo_full), 32'd0);

    // Reset in the middle of SHIFT.
    do_reset();
    rd_en = 1'b1;
    start_capture(16'hBEEF, 1'b0);
    repeat (30) tick();
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_cs_low", 32'(adc_cs_n), 32'd0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("mid_rst_sclk", 32'(adc_sclk), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_stb", 32'(Stb), 32'd0);
    check("mid_rst_dato", 32'(dato), 32'h00);
    check("mid_rst_full", 32'(fifo_full), 32'd0);
    rst_n = 1'b1;
`ifdef ADC_TEST_PATTERN_EN
    tp = 16'h0000;
`endif
    repeat (100) tick();
    check("mid_no_stb", 32'(obs_q.size()), 32'd0);

    // Recovery after the aborted conversion, three back-to-back captures.
    capture(16'h5A5A, 1'b1);
    capture(16'h0F0F, 1'b1);
    capture(16'h8001, 1'b1);
    repeat (20) tick();
    drain_check("recover");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/adc_lector.md
# adc_lector

Capture side of the readout chain. On each `flag_adc` pulse from the sequencer, it runs one serial conversion read on the external ADC (chip select, serial clock, serial data in) and stores the 16-bit sample in an on-chip FIFO. It then streams the FIFO contents to the host interface as strobed bytes, MSB first, paced by `rd_en`. It is the return path that complements the host-to-sequencer byte write path.

## Interface
- `SCLK_DIV`, default 2: clk cycles per half period of `adc_sclk` (≥1).
- `NBITS`, default 16: bits shifted per conversion (fixed 16 in this revision).
- `FIFO_DEPTH`, default 8: samples buffered (power of two).

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `flag_adc` in 1: conversion request, one-cycle pulse from the sequencer.
- `adc_cs_n` out 1: ADC chip select, active low.
- `adc_sclk` out 1: ADC serial clock, idle low.
- `adc_sdo` in 1: ADC serial data, MSB first.
- `rd_en` in 1: host ready to accept bytes; level-sensitive.
- `dato` out 8: byte to host.
- `Stb` out 1: `dato` valid, one-cycle pulse per byte.
- `busy` out 1: capture FSM not in IDLE.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` samples.
- `overflow` out 1: sticky; a sample was dropped or a request was missed.

## Operation
- **Reset values:** `adc_cs_n`=1, `adc_sclk`=0, `dato`=0x00, `Stb`=0, `busy`=0, `fifo_full`=0, `overflow`=0. The FIFO is emptied and both FSMs go to IDLE. Reset mid-conversion aborts at once; the partial sample is discarded.
- **Capture FSM**, IDLE→CONV→SHIFT→STORE→IDLE:
  - IDLE: `flag_adc`=1 moves to CONV.
  - CONV: `adc_cs_n`=0 for `2*SCLK_DIV` cycles (setup), then moves to SHIFT.
  - SHIFT: `adc_sclk` toggles every `SCLK_DIV` cycles. `adc_sdo` is sampled into the shift register in the cycle `adc_sclk` goes 0→1. After 16 rising edges and the following falling edge, moves to STORE.
  - STORE: one cycle. `adc_cs_n`=1. The sample is written to the FIFO if it is not full. If it is full, the sample is dropped and `overflow` is set. Returns to IDLE.
- **Missed requests:** `flag_adc`=1 while `busy`=1 is ignored and sets `overflow`.
- **Emitter FSM**, E_IDLE→E_HI→E_GAP1→E_LO→E_GAP2→E_IDLE:
  - Leaves E_IDLE only when the FIFO is non-empty and `rd_en`=1; the FIFO is popped on that transition.
  - E_HI: `dato`=sample[15:8], `Stb`=1.
  - E_LO: `dato`=sample[7:0], `Stb`=1.
  - Gap states: `Stb`=0, `dato` holds.
  - If `rd_en` drops, a pair already started still completes. The emitter never splits a sample.
- **Simultaneous push and pop:** a push in STORE and a pop in the same cycle are both honoured, and occupancy is unchanged. A pop on a full FIFO with a simultaneous STORE does not overflow.
- **Pointers and clearing:** FIFO pointers wrap modulo `FIFO_DEPTH`, with an extra bit for full/empty. `overflow` is cleared only by reset.

## Timing
- `flag_adc` sampled at edge N: `adc_cs_n` falls at N+1, first `adc_sclk` rise at N+1+2·SCLK_DIV.
- Capture latency from `flag_adc` to FIFO write is 1 + 2·SCLK_DIV + 32·SCLK_DIV + 1 cycles, i.e. 70 cycles at the default.
- Minimum request spacing is that latency plus 1 IDLE cycle (71 cycles at the default).
- Emitter with `rd_en` held high and FIFO non-empty: MSB `Stb` 1 cycle after the pop, LSB `Stb` 2 cycles later. Throughput is 1 sample per 5 cycles.
- `fifo_full` and `busy` are registered and update the cycle after the causing edge.

## Configuration
- `ADC_TEST_PATTERN_EN`:
  - Defined: STORE writes a 16-bit counter instead of the shift register. The counter resets to 0x0000 and increments after each store attempt, including dropped ones. The SPI pins still toggle exactly as in normal mode.
  - Undefined: the shift register contents are stored. No counter logic is present.

## Structure
- The shared package holds:
  - capture state encodings (IDLE, CONV, SHIFT, STORE) and emitter state encodings;
  - the byte-order constant (MSB first);
  - `NBITS`.
- Sub-module `fifo_muestras`: synchronous FIFO, 16 bits × `FIFO_DEPTH`, with push, pop, full and empty outputs. Read data is valid combinationally at the head.

## Test plan
- **Single capture:** ADC model returns 0xA5C3, `rd_en`=1, one `flag_adc` pulse → `adc_cs_n` low 69 cycles; then `Stb` pulses with `dato`=0xA5, then 0xC3 two cycles later.
- **Back-pressure:** `rd_en`=0 and 8 captures 0x0001..0x0008 → `fifo_full`=1, no `Stb`. Raise `rd_en` → 16 bytes 00 01 00 02 … 00 08 in order.
- **Overflow:** with `fifo_full`=1, trigger a ninth capture (0xFFFF) → `overflow`=1 and 0xFFFF is never emitted.
- **Missed request:** second `flag_adc` 20 cycles after the first → ignored, `overflow`=1, exactly one sample stored.
- **Reset mid-operation:** assert `rst_n`=0 during SHIFT → next cycle `adc_cs_n`=1, `adc_sclk`=0, FIFO empty, no `Stb`.
- **Test pattern:** with `ADC_TEST_PATTERN_EN` defined, 3 captures → bytes 00 00 00 01 00 02.
